fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer between the IF-stage PC and an instruction memory with a req/ack handshake.
//  Owns the fetch PC and issues one memory request at a time. Holds each returned instruction
//  in an output register until the IF/ID latch accepts it. Applies the predictor's next-PC choice
//  and EX-stage redirects, and discards in-flight fetches that a redirect kills.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC loaded on reset
//  CNT_W     16             width of each perf counter (FETCH_PERF_EN only)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  pred_taken   in   1   predictor taken for current pc; valid in the imem_ack cycle
//  pred_target  in   32  predicted target for current pc
//  redirect_ex  in   1   EX resolved mispredict/branch; highest priority
//  redirect_pc  in   32  corrected fetch address
//  imem_req     out  1   memory request (registered)
//  imem_addr    out  32  request address; equals pc
//  imem_ack     in   1   memory response valid; may arrive in the cycle req rises
//  imem_rdata   in   32  instruction data, valid with imem_ack
//  pc           out  32  current fetch PC
//  inst         out  32  buffered instruction
//  inst_pc      out  32  PC of buffered instruction
//  inst_valid   out  1   buffer holds a live instruction
//  inst_ready   in   1   IF/ID accepts; consume = inst_valid & inst_ready
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, imem_req=0, inst=0, inst_pc=0, inst_valid=0, state=IDLE.
//  States (all outputs registered; imem_req=1 in FETCH and KILL only):
//   IDLE : next cycle -> FETCH. Entered only from reset.
//   FETCH: req high; addr stable until ack.
//          On ack without redirect: inst<=rdata, inst_pc<=pc, inst_valid<=1.
//          Also pc <= pred_taken ? pred_target : pc+4. State -> DRAIN.
//   DRAIN: req low; inst/inst_pc held stable. On consume: inst_valid<=0, -> FETCH.
//   KILL : req held with old addr until ack; rdata dropped. On ack -> FETCH at new pc.
//  Redirect (redirect_ex=1) always loads pc <= {redirect_pc[31:2],2'b00} and clears inst_valid.
//  Next state depends on the current state and on imem_ack:
//   FETCH, no ack this cycle -> KILL; the address change is deferred until the ack.
//   FETCH with ack, or KILL with ack -> FETCH; data is discarded, new request next cycle.
//   KILL without ack -> stay KILL; pc updated (last redirect wins).
//   DRAIN -> FETCH; a consume in the same cycle is ignored, the instruction is flushed.
//   IDLE -> FETCH at redirect_pc.
//  imem_addr drives the registered request address. In KILL it stays on the killed address.
//  Throughput: max 1 inst / 2 cycles with a zero-wait memory (ack->valid, consume->req).
//  pc+4 wraps modulo 2^32. pred_target is used unmasked; only redirect_pc is aligned.
//  pred_taken/pred_target are sampled only on a non-killed ack in FETCH; otherwise ignored.
//  imem_ack outside FETCH/KILL is ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined adds three outputs, CNT_W bits each, saturating at all-ones, reset 0:
//   perf_fetch_cnt: +1 per consume.
//   perf_redirect_cnt: +1 per cycle with redirect_ex.
//   perf_wait_cnt: +1 per cycle in FETCH/KILL without ack.
//  FETCH_PERF_EN undefined: these ports and counters do not exist; other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-FETCH -> same cycle imem_req=0, inst_valid=0, pc=0.
//    Release -> req=1 addr=0x0 on 2nd edge.
//  2 Sequential: zero-wait ack, inst_ready=1, rdata=addr^0xA5 -> inst_pc 0x0,0x4,0x8.
//    Each valid 1 cycle, every 2 cycles; inst matches.
//  3 Prediction: ack at pc=0x8 with pred_taken=1, pred_target=0x40 -> next imem_addr=0x40.
//    pred_taken=0 case -> 0xC.
//  4 Backpressure: inst_ready=0 for 5 cycles after valid -> inst/inst_pc stable, req=0.
//    Ready=1 -> req next cycle.
//  5 Kill: ack latency 3, redirect_ex to 0x100 one cycle after req -> addr stays 0x0 until ack.
//    No inst_valid for it; next req addr=0x100.
//  6 Corners: redirect coincident with ack and, separately, with consume -> both flushed.
//    redirect_pc=0x103 -> addr 0x100. pc=0xFFFF_FFFC +4 -> 0x0.
//    With FETCH_PERF_EN, counters match and saturate at CNT_W=2.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time and buffers the returned
// instruction until IF/ID consumes it. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        redirect_ex,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_redirect_cnt,
    output logic [CNT_W-1:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instPc_q, instPc_d;
    logic        req_q, req_d;
    logic        instValid_q, instValid_d;

    logic [31:0] redirTarget;
    logic [31:0] seqPc;
    logic        consume;

    assign redirTarget = redirect_pc & 32'hFFFF_FFFC;
    assign seqPc       = pc_q + 32'd4;
    assign consume     = instValid_q & inst_ready;

    // A redirect always retargets pc and flushes the buffer; the state decides whether the
    // outstanding request must first be drained (KILL) before the new address goes out.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        instPc_d    = instPc_q;
        req_d       = req_q;
        instValid_d = instValid_q;

        if (redirect_ex) begin
            pc_d        = redirTarget;
            instValid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_d;
            end
            FETCH: begin
                if (redirect_ex) begin
                    if (imem_ack) begin
                        state_d = FETCH;
                        addr_d  = pc_d;
                    end else begin
                        state_d = KILL;
                    end
                end else if (imem_ack) begin
                    inst_d      = imem_rdata;
                    instPc_d    = pc_q;
                    instValid_d = 1'b1;
                    pc_d        = pred_taken ? pred_target : seqPc;
                    addr_d      = pc_d;
                    req_d       = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_ex || consume) begin
                    instValid_d = 1'b0;
                    req_d       = 1'b1;
                    addr_d      = pc_d;
                    state_d     = FETCH;
                end
            end
            KILL: begin
                // The killed request keeps its address on the bus until memory answers it.
                if (imem_ack) begin
                    addr_d  = pc_d;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            inst_q      <= 32'h0;
            instPc_q    <= 32'h0;
            req_q       <= 1'b0;
            instValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            instPc_q    <= instPc_d;
            req_q       <= req_d;
            instValid_q <= instValid_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = instPc_q;
    assign inst_valid = instValid_q;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] perfFetch_q, perfRedirect_q, perfWait_q;
    logic             waiting;

    assign waiting = ((state_q == FETCH) || (state_q == KILL)) && !imem_ack;

    // All three counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfFetch_q    <= '0;
            perfRedirect_q <= '0;
            perfWait_q     <= '0;
        end else begin
            if (consume && (perfFetch_q != '1)) begin
                perfFetch_q <= perfFetch_q + CNT_W'(1);
            end
            if (redirect_ex && (perfRedirect_q != '1)) begin
                perfRedirect_q <= perfRedirect_q + CNT_W'(1);
            end
            if (waiting && (perfWait_q != '1)) begin
                perfWait_q <= perfWait_q + CNT_W'(1);
            end
        end
    end

    assign perf_fetch_cnt    = perfFetch_q;
    assign perf_redirect_cnt = perfRedirect_q;
    assign perf_wait_cnt     = perfWait_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: memory model with random latency, architectural next-PC model and
// a scoreboard of expected instructions. Honours FETCH_PERF_EN when defined.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
`ifdef FETCH_PERF_EN
    localparam int CNT_W_TB = 2;
    localparam int SAT_MAX  = (1 << CNT_W_TB) - 1;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = 32'h0;
    logic        redirect_ex = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [CNT_W_TB-1:0] perfFetchCnt, perfRedirectCnt, perfWaitCnt;
    int fetchCnt = 0, redirCnt = 0, waitCnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Architectural model state
    item_t       scoreQ[$];
    logic [31:0] modelPc = RESET_PC_TB;
    logic        expValid = 1'b0;
    logic        expectReqNext = 1'b0;
    logic        txActive = 1'b0;
    int          txLeft = 0;
    int          txEpoch = 0;
    int          epoch = 0;
    logic [31:0] txAddr = 32'h0;

    always #5 clk = ~clk;

`ifdef FETCH_PERF_EN
    fetch_ctrl #(.RESET_PC(RESET_PC_TB), .CNT_W(CNT_W_TB)) dut (
`else
    fetch_ctrl #(.RESET_PC(RESET_PC_TB)) dut (
`endif
        .clk(clk),
        .rst(rst),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .redirect_ex(redirect_ex),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perfFetchCnt),
        .perf_redirect_cnt(perfRedirectCnt),
        .perf_wait_cnt(perfWaitCnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic int satInc(input int v);
`ifdef FETCH_PERF_EN
        return (v < SAT_MAX) ? v + 1 : v;
`else
        return v + 1;
`endif
    endfunction

    task automatic resetModel();
        scoreQ.delete();
        modelPc       = RESET_PC_TB;
        expValid      = 1'b0;
        expectReqNext = 1'b0;
        txActive      = 1'b0;
        txLeft        = 0;
        epoch         = 0;
        txEpoch       = 0;
`ifdef FETCH_PERF_EN
        fetchCnt = 0;
        redirCnt = 0;
        waitCnt  = 0;
`endif
    endtask

    // One clock of stimulus: check the visible state, play memory, drive inputs, advance the model.
    task automatic applyStimulus(input int lat, input logic redir, input logic [31:0] rpc,
                                 input logic rdy, input logic pt, input logic [31:0] ptgt);
        logic ack;
        logic consumeNow;
        @(negedge clk);
        #1;
        checkOutput("pc", pc, modelPc);
        checkOutput("instValid", 32'(inst_valid), 32'(expValid));
        if (expValid) checkOutput("reqWhileHeld", 32'(imem_req), 32'(0));
        if (expectReqNext) checkOutput("reqAfterRelease", 32'(imem_req), 32'(1));
        if (txActive) begin
            checkOutput("reqHeld", 32'(imem_req), 32'(1));
            checkOutput("addrHeld", imem_addr, txAddr);
        end
`ifdef FETCH_PERF_EN
        checkOutput("perfFetch", 32'(perfFetchCnt), 32'(fetchCnt));
        checkOutput("perfRedirect", 32'(perfRedirectCnt), 32'(redirCnt));
        checkOutput("perfWait", 32'(perfWaitCnt), 32'(waitCnt));
`endif
        if (imem_req && !txActive) begin
            checkOutput("reqAddr", imem_addr, modelPc);
            txActive = 1'b1;
            txLeft   = lat;
            txEpoch  = epoch;
            txAddr   = imem_addr;
        end
        ack = txActive && (txLeft == 0);
        if (txActive && !ack) txLeft--;

        imem_ack    = ack;
        imem_rdata  = ack ? (txAddr ^ 32'h0000_00A5) : $urandom;
        redirect_ex = redir;
        redirect_pc = rpc;
        inst_ready  = rdy;
        pred_taken  = pt;
        pred_target = ptgt;

        consumeNow = expValid && rdy;
`ifdef FETCH_PERF_EN
        if (consumeNow) fetchCnt = satInc(fetchCnt);
        if (redir) redirCnt = satInc(redirCnt);
        if (txActive && !ack) waitCnt = satInc(waitCnt);
`endif
        expectReqNext = 1'b0;
        if (redir) begin
            modelPc       = rpc & 32'hFFFF_FFFC;
            expValid      = 1'b0;
            expectReqNext = 1'b1;
            epoch++;
        end else begin
            if (consumeNow) begin
                expValid      = 1'b0;
                expectReqNext = 1'b1;
            end
            if (ack) begin
                if (txEpoch == epoch) begin
                    if (scoreQ.size() != 0) checkOutput("unpresentedInst", 32'(scoreQ.size()), 32'(0));
                    scoreQ.push_back('{inst: modelPc ^ 32'h0000_00A5, pc: modelPc});
                    expValid = 1'b1;
                    modelPc  = pt ? ptgt : modelPc + 32'd4;
                end else begin
                    expectReqNext = 1'b1;
                end
            end
        end
        if (ack) txActive = 1'b0;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        imem_ack    = 1'b0;
        redirect_ex = 1'b0;
        inst_ready  = 1'b0;
        pred_taken  = 1'b0;
        #1;
        checkOutput("rstReq", 32'(imem_req), 32'(0));
        checkOutput("rstValid", 32'(inst_valid), 32'(0));
        checkOutput("rstPc", pc, RESET_PC_TB);
        checkOutput("rstInst", inst, 32'h0);
        checkOutput("rstInstPc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("idleReq", 32'(imem_req), 32'(0));
        @(posedge clk);
        #1;
        checkOutput("firstReq", 32'(imem_req), 32'(1));
        checkOutput("firstAddr", imem_addr, RESET_PC_TB);
    endtask

    task automatic waitHeld();
        int n = 0;
        while (!expValid && n < 40) begin
            applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        if (!expValid) reportTimeout("waitHeld");
    endtask

    // Scoreboard monitor: each new presentation pops one expected entry; it must then stay stable.
    initial begin : monitor
        item_t cur;
        logic  prevValid;
        cur = '0;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
            end else begin
                if (inst_valid && !prevValid) begin
                    if (scoreQ.size() == 0) begin
                        checkOutput("unexpectedInst", 32'(inst_valid), 32'(0));
                    end else begin
                        cur = scoreQ.pop_front();
                        checkOutput("inst", inst, cur.inst);
                        checkOutput("instPc", inst_pc, cur.pc);
                    end
                end else if (inst_valid) begin
                    checkOutput("instStable", inst, cur.inst);
                    checkOutput("instPcStable", inst_pc, cur.pc);
                end
                prevValid = inst_valid;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        #2;
        doReset();

        $display("[TB] sequential fetch");
        repeat (8) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("[TB] prediction");
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040);
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("[TB] backpressure");
        waitHeld();
        repeat (6) applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("[TB] kill");
        waitHeld();
        applyStimulus(3, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(3, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        repeat (6) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("[TB] reset during fetch");
        waitHeld();
        applyStimulus(8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        doReset();
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("[TB] corner cases");
        waitHeld();
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0);
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        waitHeld();
        applyStimulus(0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        waitHeld();
        applyStimulus(0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        repeat (6) applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3),
                          ($urandom_range(0, 11) == 0),
                          $urandom,
                          ($urandom_range(0, 9) < 7),
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        end
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        @(negedge clk);
        #2;
        checkOutput("leftoverEntries", 32'(scoreQ.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
